// File: rtl/clkctrl_pkg.sv
// rtl/clkctrl_pkg.sv - shared state encoding and default constants for the CPU clock controller
package clkctrl_pkg;

  localparam int CLKCTRL_DIV_W       = 3;
  localparam int CLKCTRL_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    LS_RUN   = 2'd0,
    SW_TO_HS = 2'd1,
    HS_RUN   = 2'd2,
    SW_TO_LS = 2'd3
  } clkctrl_state_t;

endpackage

// File: rtl/clkctrl_sync.sv
// rtl/clkctrl_sync.sv - N-stage reset-to-0 single-bit synchroniser
module clkctrl_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clkctrl_phi2_div.sv
// rtl/clkctrl_phi2_div.sv - glitch-free CPU clock from divider or LS clock; CLKCTRL_RDY_ON_CLKSW_EN gates rdy during switches
module clkctrl_phi2_div
  import clkctrl_pkg::*;
#(
  parameter int DIV_W       = CLKCTRL_DIV_W,
  parameter int SYNC_STAGES = CLKCTRL_SYNC_STAGES
) (
  input  logic             hsclk_in,
  input  logic             rst_b,
  input  logic             lsclk_in,
  input  logic             hsclk_sel,
  input  logic [DIV_W-1:0] cpuclk_div_sel,
  output logic             clkout,
  output logic             hsclk_selected,
  output logic             lsclk_selected,
  output logic             rdy,
  output logic             phi2_end
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic           ls_s;
  logic           ls_p_q;
  logic           ls_rise;
  logic           ls_fall;

  clkctrl_state_t state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic           clkout_q, clkout_d;
  logic           seen_rise_q, seen_rise_d;
  logic           hs_sel_q;
  logic           ls_sel_q;
  logic           phi2_end_q;

  clkctrl_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ls_sync (
    .clk_i  (hsclk_in),
    .rst_ni (rst_b),
    .d_i    (lsclk_in),
    .q_o    (ls_s)
  );

  assign ls_rise = ls_s & ~ls_p_q;
  assign ls_fall = ~ls_s & ls_p_q;

  // Next-state logic: every switch parks clkout high until the new source is aligned
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    clkout_d    = clkout_q;
    seen_rise_d = seen_rise_q;
    case (state_q)
      LS_RUN: begin
        clkout_d = ls_s;
        if (hsclk_sel && ls_rise) begin
          clkout_d = 1'b1;
          cnt_d    = cpuclk_div_sel;
          div_d    = cpuclk_div_sel;
          state_d  = SW_TO_HS;
        end
      end
      SW_TO_HS: begin
        clkout_d = 1'b1;
        if (cnt_q == '0) begin
          clkout_d = 1'b0;
          cnt_d    = div_q;
          state_d  = HS_RUN;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HS_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (clkout_q) begin
          clkout_d = 1'b0;
          cnt_d    = div_q;
        end else if (hsclk_sel) begin
          // new cycle start: the only point where the divider code is taken
          clkout_d = 1'b1;
          div_d    = cpuclk_div_sel;
          cnt_d    = cpuclk_div_sel;
        end else begin
          clkout_d    = 1'b1;
          seen_rise_d = 1'b0;
          state_d     = SW_TO_LS;
        end
      end
      SW_TO_LS: begin
        // only a rise seen here counts, so a full LS high phase elapses first
        clkout_d = 1'b1;
        if (ls_rise) begin
          seen_rise_d = 1'b1;
        end
        if (ls_fall && seen_rise_q) begin
          clkout_d = 1'b0;
          state_d  = LS_RUN;
        end
      end
      default: begin
        state_d = LS_RUN;
      end
    endcase
  end

  // State, edge-detect and registered output flops
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= LS_RUN;
      ls_p_q      <= 1'b0;
      cnt_q       <= '0;
      div_q       <= '0;
      clkout_q    <= 1'b0;
      seen_rise_q <= 1'b0;
      hs_sel_q    <= 1'b0;
      ls_sel_q    <= 1'b1;
      phi2_end_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ls_p_q      <= ls_s;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      clkout_q    <= clkout_d;
      seen_rise_q <= seen_rise_d;
      hs_sel_q    <= (state_d == HS_RUN);
      ls_sel_q    <= (state_d == LS_RUN);
      phi2_end_q  <= clkout_q & ~clkout_d;
    end
  end

`ifdef CLKCTRL_RDY_ON_CLKSW_EN
  logic rdy_q;

  // Hold the CPU off while the clock is parked in a switch state
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      rdy_q <= 1'b1;
    end else begin
      rdy_q <= (state_d == LS_RUN) || (state_d == HS_RUN);
    end
  end

  assign rdy = rdy_q;
`else
  assign rdy = 1'b1;
`endif

  assign clkout         = clkout_q;
  assign hsclk_selected = hs_sel_q;
  assign lsclk_selected = ls_sel_q;
  assign phi2_end       = phi2_end_q;

endmodule

// File: doc/clkctrl_phi2_div.md
# clkctrl_phi2_div

Single-clock CPU clock controller with a parametrised divider. It generates the CPU clock as a registered, glitch-free output from the fast oscillator `hsclk_in`. The output runs either from a programmable divider or locked to the slow system clock `lsclk_in`, which is sampled as data through a synchroniser. Every switch parks the clock in the PHI2 (high) state, so no phase is ever shorter than a full phase of the source being left. The block sits between the board oscillators and the CPU clock pin, and its selection feedback goes to the address decode logic.

## Interface
- `DIV_W`, 3: width of `cpuclk_div_sel`. In HS mode each phase lasts `cpuclk_div_sel+1` ticks.
- `SYNC_STAGES`, 2: flops in the `lsclk_in` synchroniser. Legal range 2..4.
- `hsclk_in`  in  1  sole clock (all logic on its rising edge).
- `rst_b`  in  1  reset, asynchronous assert, active-low.
- `lsclk_in`  in  1  slow system clock, asynchronous to `hsclk_in`, used as data only.
- `hsclk_sel`  in  1  1 requests divider mode, 0 requests LS-locked mode. Level-sensitive.
- `cpuclk_div_sel`  in  DIV_W  divider code, sampled at each HS cycle start.
- `clkout`  out  1  CPU clock, driven directly from a flop.
- `hsclk_selected`  out  1  1 only in state HS_RUN.
- `lsclk_selected`  out  1  1 only in state LS_RUN.
- `rdy`  out  1  CPU ready (see Configuration).
- `phi2_end`  out  1  one-tick pulse registered with each 1→0 transition of `clkout`.

## Operation
- `lsclk_in` passes through `SYNC_STAGES` flops to give `ls_s`.
- A further flop holds `ls_p`. Rise of the synchronised LS clock: `ls_s & !ls_p`. Fall: `!ls_s & ls_p`.
- States:
  - LS_RUN: `clkout <= ls_s`. If `!hsclk_sel` there is no change. If `hsclk_sel` and a rise is seen, set `clkout` to 1, load `cnt` with the current code, and go to SW_TO_HS.
  - SW_TO_HS: `clkout` is held at 1. Decrement `cnt`. When `cnt==0`, set `clkout` to 0, reload `cnt`, and go to HS_RUN.
  - HS_RUN: divider running. `cnt` counts each phase down. At `cnt==0`, toggle `clkout`. At the end of a low phase:
    - if `hsclk_sel` is 1, latch `cpuclk_div_sel` into `div_q` and start a new high phase;
    - otherwise set `clkout` to 1, clear `seen_rise`, and go to SW_TO_LS.
  - SW_TO_LS: `clkout` is held at 1. Set `seen_rise` on a rise. On a fall with `seen_rise` set, set `clkout` to 0 and go to LS_RUN.
- `div_q` changes only at an HS cycle start. A code change mid-cycle takes effect from the next cycle.
- Once a switch state is entered, it always completes, even if `hsclk_sel` toggles. The opposite request is then evaluated from the new RUN state.
- A SW_TO_LS entered with `ls_s` high waits for the next full LS high phase. Only a rise seen inside SW_TO_LS counts.
- `phi2_end` is asserted on every 1→0 transition of `clkout`, in all states.

## Timing
- Reset values:
  - state LS_RUN; `clkout`=0; `lsclk_selected`=1; `hsclk_selected`=0; `rdy`=1; `phi2_end`=0;
  - synchroniser, `ls_p`, `cnt` and `div_q` all 0.
- HS period is `2*(div_q+1)` ticks, with 50% duty. Code 0 gives `hsclk_in`/2.
- In LS mode, `clkout` lags `lsclk_in` by `SYNC_STAGES+1` ticks, with ±1 tick jitter.
- The stretched PHI2 high is at least `div_q+1` ticks (entering HS) or one full synchronised LS high phase (entering LS).
- Reset asserted mid-operation returns all state to the reset values immediately.
- The first LS edges after release are honoured only once the synchroniser has filled.

## Configuration
- Macro `CLKCTRL_RDY_ON_CLKSW_EN`.
  - Defined: `rdy` is 0 in SW_TO_HS and SW_TO_LS, and 1 otherwise, registered with the state.
  - Undefined: `rdy` is constant 1.

## Structure
- Shared package `clkctrl_pkg` holds:
  - the state encoding, four states, with typedef `clkctrl_state_t`;
  - the default constants `CLKCTRL_DIV_W`=3 and `CLKCTRL_SYNC_STAGES`=2.
- Sub-module `clkctrl_sync`: an N-stage reset-to-0 bit synchroniser, instantiated once for `lsclk_in`.

## Test plan
- Reset with `hsclk_sel`=0 and `lsclk_in` at 1 MHz, `hsclk_in` at 16 MHz → `clkout` follows `lsclk_in` delayed 3 ticks; `lsclk_selected`=1.
- Raise `hsclk_sel`, code 1 → after the next synchronised LS rise, `clkout` is high 2 ticks and then low 2 ticks, giving a period of 4 ticks; `hsclk_selected`=1 from the first HS low phase.
- In HS_RUN, change the code 1→3 mid-high-phase → the current cycle completes at 4 ticks, and the next cycle is 8 ticks.
- Drop `hsclk_sel` → `clkout` is held at 1 until a full LS high phase has passed, then falls with `ls_s`; there are no pulses shorter than 2 ticks; `phi2_end` pulses once per fall.
- Toggle `hsclk_sel` 1→0 within SW_TO_HS → the block enters HS_RUN, completes one HS cycle, then enters SW_TO_LS.
- Assert `rst_b` in SW_TO_LS → all outputs return to their reset values.
- With `CLKCTRL_RDY_ON_CLKSW_EN` defined → `rdy`=0 exactly across the switch states.
